// File: rtl/fft_seq_ctrl_if.sv
// Handshake and memory-port bundle between the FFT sequencer and the datapath.
// master = sequencer side, slave = butterfly/RAM side that supplies start.
interface fft_seq_ctrl_if #(
    parameter int unsigned LOG2N = 4
);
    localparam int unsigned StageW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    logic                 start;
    logic                 rd_en;
    logic [LOG2N-1:0]     rd_addr_a;
    logic [LOG2N-1:0]     rd_addr_b;
    logic [LOG2N-2:0]     tw_addr;
    logic                 wr_en;
    logic [LOG2N-1:0]     wr_addr_a;
    logic [LOG2N-1:0]     wr_addr_b;
    logic [StageW-1:0]    stage;
    logic                 busy;
    logic                 done;

    modport master (
        input  start,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b,
        output stage, busy, done
    );

    modport slave (
        output start,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b,
        input  stage, busy, done
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Radix-2 in-place FFT address sequencer: issues one butterfly per cycle, drains the
// read-to-writeback pipeline between stages and replays read addresses as write addresses.
module fft_seq_ctrl #(
    parameter int unsigned LOG2N    = 4,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    fft_seq_ctrl_if.master bus
);
    localparam int unsigned StageW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int unsigned KW     = LOG2N - 1;
    localparam int unsigned CntW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [KW-1:0]     KLast   = '1;
    localparam logic [StageW-1:0] SLast   = StageW'(LOG2N - 1);
    localparam logic [CntW-1:0]   CntInit = CntW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [StageW-1:0] s_q, s_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              rd_en_q, rd_en_d;
    logic [LOG2N-1:0]  rd_addr_a_q, rd_addr_a_d;
    logic [LOG2N-1:0]  rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]     tw_addr_q, tw_addr_d;
    logic [StageW-1:0] stage_q, stage_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pipe_en_q [PIPE_LAT];
    logic [LOG2N-1:0]  pipe_a_q  [PIPE_LAT];
    logic [LOG2N-1:0]  pipe_b_q  [PIPE_LAT];

    logic [KW-1:0]     pos;
    logic [LOG2N-1:0]  addr_a;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    state_d = StDrain;
                    cnt_d   = CntInit;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    if (s_q == SLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        s_d     = s_q + StageW'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                s_d     = '0;
                k_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    // When s = LOG2N-1 the mask below wraps to all ones, which is exactly pos = k.
    always_comb begin
        pos    = k_d & ((KW'(1) << s_d) - KW'(1));
        addr_a = (((LOG2N'(k_d) >> s_d) << s_d) << 1) | LOG2N'(pos);

        rd_en_d     = (state_d == StRun);
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        tw_addr_d   = '0;
        if (rd_en_d) begin
            rd_addr_a_d = addr_a;
            rd_addr_b_d = addr_a | (LOG2N'(1) << s_d);
            tw_addr_d   = pos << (KW - s_d);
        end
        busy_d  = (state_d == StRun) || (state_d == StDrain);
        done_d  = (state_d == StDone);
        stage_d = busy_d ? s_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            s_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            stage_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            stage_q     <= stage_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Read addresses are already zero when idle, so the delayed copies are zero without wr_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a_q[i]  <= '0;
                pipe_b_q[i]  <= '0;
            end
        end else begin
            pipe_en_q[0] <= rd_en_q;
            pipe_a_q[0]  <= rd_addr_a_q;
            pipe_b_q[0]  <= rd_addr_b_q;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                pipe_en_q[i] <= pipe_en_q[i-1];
                pipe_a_q[i]  <= pipe_a_q[i-1];
                pipe_b_q[i]  <= pipe_b_q[i-1];
            end
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.tw_addr   = tw_addr_q;
    assign bus.wr_en     = pipe_en_q[PIPE_LAT-1];
    assign bus.wr_addr_a = pipe_a_q[PIPE_LAT-1];
    assign bus.wr_addr_b = pipe_b_q[PIPE_LAT-1];
    assign bus.stage     = stage_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl with default parameters (N=16, 3-cycle pipeline).
module tb_fft_seq_ctrl;
    localparam int LOG2N    = 4;
    localparam int PIPE_LAT = 3;
    localparam int HALF_N   = 8;
    localparam int STG_LEN  = HALF_N + PIPE_LAT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_seq_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_seq_ctrl #(
        .LOG2N   (LOG2N),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       rd_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] tw;
        logic       wr_en;
        logic [3:0] wa;
        logic [3:0] wb;
        logic [1:0] stage;
        logic       busy;
        logic       done;
    } snap_t;

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } vec_t;

    typedef struct {
        int a;
        int b;
        int s;
        int due;
    } wb_t;

    snap_t log_q [100];
    vec_t  vecs  [8];
    wb_t   sb_q  [$];
    int    checks = 0;
    int    errors = 0;

    function automatic snap_t sample();
        snap_t r;
        r.rd_en = bus.rd_en;
        r.ra    = bus.rd_addr_a;
        r.rb    = bus.rd_addr_b;
        r.tw    = bus.tw_addr;
        r.wr_en = bus.wr_en;
        r.wa    = bus.wr_addr_a;
        r.wb    = bus.wr_addr_b;
        r.stage = bus.stage;
        r.busy  = bus.busy;
        r.done  = bus.done;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // log_q[0] is sampled in the start cycle; log_q[n] is sampled n edges later.
    task automatic capture(input int ncyc, input bit hold, input bit extra_pulses);
        log_q[0] = sample();
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            log_q[n] = sample();
            bus.start = hold || (extra_pulses && (n == 10 || n == 45));
        end
    endtask

    task automatic check_run(input string tag);
        int  erd, ea, eb, etw, ewr, ewa, ewb, ebusy, edone, estg;
        int  s, r, half, pos, grp, m;
        int  nrd, nwr, dups;
        int  first_rd [4];
        int  last_wr  [4];
        logic [15:0] mask [4];
        wb_t w;
        nrd = 0; nwr = 0; dups = 0;
        for (int i = 0; i < 4; i++) begin
            first_rd[i] = -1; last_wr[i] = -1; mask[i] = '0;
        end
        sb_q.delete();
        for (int n = 0; n <= 48; n++) begin
            erd = 0; ea = 0; eb = 0; etw = 0; ewr = 0; ewa = 0; ewb = 0; estg = 0;
            ebusy = (n >= 1 && n <= 44) ? 1 : 0;
            edone = (n == 45) ? 1 : 0;
            for (int d = 0; d <= PIPE_LAT; d += PIPE_LAT) begin
                m = n - d;
                if (m >= 1 && m <= 44) begin
                    s = (m - 1) / STG_LEN;
                    r = (m - 1) % STG_LEN;
                    if (d == 0) estg = s;
                    if (r < HALF_N) begin
                        half = 1 << s;
                        pos  = r % half;
                        grp  = r / half;
                        if (d == 0) begin
                            erd = 1; ea = 2 * half * grp + pos; eb = ea + half;
                            etw = pos * (1 << (LOG2N - 1 - s));
                        end else begin
                            ewr = 1; ewa = 2 * half * grp + pos; ewb = ewa + half;
                        end
                    end
                end
            end
            chk($sformatf("%s busy c%0d", tag, n), int'(log_q[n].busy), ebusy);
            chk($sformatf("%s done c%0d", tag, n), int'(log_q[n].done), edone);
            chk($sformatf("%s stage c%0d", tag, n), int'(log_q[n].stage), estg);
            chk($sformatf("%s rd_en c%0d", tag, n), int'(log_q[n].rd_en), erd);
            chk($sformatf("%s rd_a c%0d", tag, n), int'(log_q[n].ra), ea);
            chk($sformatf("%s rd_b c%0d", tag, n), int'(log_q[n].rb), eb);
            chk($sformatf("%s tw c%0d", tag, n), int'(log_q[n].tw), etw);
            chk($sformatf("%s wr_en c%0d", tag, n), int'(log_q[n].wr_en), ewr);
            chk($sformatf("%s wr_a c%0d", tag, n), int'(log_q[n].wa), ewa);
            chk($sformatf("%s wr_b c%0d", tag, n), int'(log_q[n].wb), ewb);

            // Scoreboard: each read schedules its writeback PIPE_LAT cycles later.
            if (log_q[n].rd_en) begin
                nrd++;
                s = int'(log_q[n].stage);
                if (first_rd[s] < 0) first_rd[s] = n;
                sb_q.push_back('{a: int'(log_q[n].ra), b: int'(log_q[n].rb), s: s,
                                 due: n + PIPE_LAT});
            end
            if (log_q[n].wr_en) begin
                nwr++;
                if (sb_q.size() == 0) begin
                    chk($sformatf("%s unexpected wr c%0d", tag, n), 1, 0);
                end else begin
                    w = sb_q.pop_front();
                    chk($sformatf("%s sb wr_a c%0d", tag, n), int'(log_q[n].wa), w.a);
                    chk($sformatf("%s sb wr_b c%0d", tag, n), int'(log_q[n].wb), w.b);
                    chk($sformatf("%s sb due c%0d", tag, n), n, w.due);
                    last_wr[w.s] = n;
                    if (mask[w.s][log_q[n].wa]) dups++;
                    mask[w.s][log_q[n].wa] = 1'b1;
                    if (mask[w.s][log_q[n].wb]) dups++;
                    mask[w.s][log_q[n].wb] = 1'b1;
                end
            end
        end
        chk({tag, " rd count"}, nrd, 32);
        chk({tag, " wr count"}, nwr, 32);
        chk({tag, " sb drained"}, sb_q.size(), 0);
        chk({tag, " dup writes"}, dups, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s stage%0d coverage", tag, i), int'(mask[i]), 16'hFFFF);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s hazard s%0d", tag, i),
                (first_rd[i+1] > last_wr[i]) ? 1 : 0, 1);
        end
    endtask

    initial begin
        int n, ndone;
        vecs[0] = '{s: 0, k: 3, a: 6,  b: 7,  tw: 0};
        vecs[1] = '{s: 1, k: 3, a: 5,  b: 7,  tw: 4};
        vecs[2] = '{s: 2, k: 6, a: 10, b: 14, tw: 4};
        vecs[3] = '{s: 3, k: 5, a: 5,  b: 13, tw: 5};
        vecs[4] = '{s: 0, k: 0, a: 0,  b: 1,  tw: 0};
        vecs[5] = '{s: 1, k: 2, a: 4,  b: 6,  tw: 0};
        vecs[6] = '{s: 2, k: 3, a: 3,  b: 7,  tw: 6};
        vecs[7] = '{s: 3, k: 7, a: 7,  b: 15, tw: 7};

        // Reset state
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", int'(sample()), 0);
        bus.start = 1'b1;
        @(negedge clk);
        chk("reset ignores start", int'(sample()), 0);
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle outputs", int'(sample()), 0);

        // Single transform, with stray start pulses during RUN and DONE
        bus.start = 1'b1;
        capture(48, 1'b0, 1'b1);
        check_run("run1");
        for (int i = 0; i < 8; i++) begin
            n = 1 + vecs[i].s * STG_LEN + vecs[i].k;
            chk($sformatf("vec%0d a", i), int'(log_q[n].ra), vecs[i].a);
            chk($sformatf("vec%0d b", i), int'(log_q[n].rb), vecs[i].b);
            chk($sformatf("vec%0d tw", i), int'(log_q[n].tw), vecs[i].tw);
        end

        // Start held high: back-to-back transforms, 46-cycle period
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        capture(95, 1'b1, 1'b0);
        ndone = 0;
        for (int i = 1; i <= 95; i++) if (log_q[i].done) ndone++;
        chk("hold done count", ndone, 2);
        chk("hold done c45", int'(log_q[45].done), 1);
        chk("hold idle c46", int'(log_q[46].busy), 0);
        chk("hold restart busy c47", int'(log_q[47].busy), 1);
        chk("hold restart rd c47", int'(log_q[47].rd_en), 1);
        chk("hold busy c90", int'(log_q[90].busy), 1);
        chk("hold done c91", int'(log_q[91].done), 1);
        chk("hold done busy c91", int'(log_q[91].busy), 0);
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Mid-transform reset at cycle 20
        bus.start = 1'b1;
        capture(20, 1'b0, 1'b0);
        chk("pre-rst busy c20", int'(log_q[20].busy), 1);
        rst = 1'b1;
        #1;
        chk("async rst outputs", int'(sample()), 0);
        @(negedge clk);
        chk("rst held outputs", int'(sample()), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst quiet %0d", i), int'(sample()), 0);
        end
        bus.start = 1'b1;
        capture(48, 1'b0, 1'b0);
        check_run("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
